// File: rtl/hdmi_mode_sequencer.sv
// Frame-level controller for the HDMI timing generator: three mode presets, frame-boundary mode switching.
// Optional build macro HDMI_SEQ_MUTE_ON_SWITCH_EN adds a video mute for MUTE_FRAMES frames after each switch.
module hdmi_mode_sequencer #(
    parameter int DEFAULT_MODE  = 0,
    parameter int FRAME_CNT_W   = 16,
    parameter int START_TIMEOUT = 16,
    parameter int MUTE_FRAMES   = 2
) (
    input  logic                   I_pxl_clk,
    input  logic                   I_rst,
    input  logic                   I_run,
    input  logic                   I_mode_req,
    input  logic [1:0]             I_mode,
    input  logic                   I_tg_busy,
    output logic                   O_tg_en,
    output logic [11:0]            O_h_total,
    output logic [11:0]            O_h_sync,
    output logic [11:0]            O_h_bporch,
    output logic [11:0]            O_h_res,
    output logic [11:0]            O_v_total,
    output logic [11:0]            O_v_sync,
    output logic [11:0]            O_v_bporch,
    output logic [11:0]            O_v_res,
    output logic [1:0]             O_mode,
    output logic                   O_mode_ack,
    output logic                   O_err_mode,
    output logic                   O_err_timeout,
    output logic                   O_frame_done,
    output logic [FRAME_CNT_W-1:0] O_frame_cnt,
    output logic                   O_mute,
    output logic [2:0]             O_dbg_state
);

    // Handshake with the generator: a one-cycle O_tg_en pulse launches a frame; the generator
    // holds I_tg_busy high for the whole frame and its falling edge marks the frame boundary.

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOAD      = 3'd1,
        S_START     = 3'd2,
        S_WAIT_BUSY = 3'd3,
        S_RUN       = 3'd4
    } state_t;

    typedef struct packed {
        logic [11:0] h_total;
        logic [11:0] h_sync;
        logic [11:0] h_bporch;
        logic [11:0] h_res;
        logic [11:0] v_total;
        logic [11:0] v_sync;
        logic [11:0] v_bporch;
        logic [11:0] v_res;
    } timing_t;

    localparam logic [1:0] DEF_MODE = 2'(DEFAULT_MODE);
    localparam int         TO_W     = $clog2(START_TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(START_TIMEOUT - 1);

    function automatic timing_t preset(input logic [1:0] m);
        timing_t t;
        case (m)
            2'd1:    t = '{12'd1344, 12'd136, 12'd160, 12'd1024, 12'd806, 12'd6, 12'd29, 12'd768};
            2'd2:    t = '{12'd1650, 12'd40,  12'd220, 12'd1280, 12'd750, 12'd5, 12'd20, 12'd720};
            default: t = '{12'd1056, 12'd128, 12'd88,  12'd800,  12'd628, 12'd4, 12'd23, 12'd600};
        endcase
        return t;
    endfunction

    state_t                 state_q, state_d;
    timing_t                timing_q, timing_d;
    logic [1:0]             mode_q, mode_d;
    logic [1:0]             pend_mode_q, pend_mode_d;
    logic                   pend_q, pend_d;
    logic                   tg_en_q, tg_en_d;
    logic                   ack_q, ack_d;
    logic                   err_mode_q, err_mode_d;
    logic                   err_to_q, err_to_d;
    logic                   done_q, done_d;
    logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [TO_W-1:0]        to_cnt_q, to_cnt_d;
    logic                   frame_end;

    assign frame_end = (state_q == S_RUN) && !I_tg_busy;

    always_ff @(posedge I_pxl_clk or posedge I_rst) begin
        if (I_rst) begin
            state_q     <= S_IDLE;
            timing_q    <= preset(DEF_MODE);
            mode_q      <= DEF_MODE;
            pend_mode_q <= DEF_MODE;
            pend_q      <= 1'b0;
            tg_en_q     <= 1'b0;
            ack_q       <= 1'b0;
            err_mode_q  <= 1'b0;
            err_to_q    <= 1'b0;
            done_q      <= 1'b0;
            frame_cnt_q <= '0;
            to_cnt_q    <= '0;
        end else begin
            state_q     <= state_d;
            timing_q    <= timing_d;
            mode_q      <= mode_d;
            pend_mode_q <= pend_mode_d;
            pend_q      <= pend_d;
            tg_en_q     <= tg_en_d;
            ack_q       <= ack_d;
            err_mode_q  <= err_mode_d;
            err_to_q    <= err_to_d;
            done_q      <= done_d;
            frame_cnt_q <= frame_cnt_d;
            to_cnt_q    <= to_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        timing_d    = timing_q;
        mode_d      = mode_q;
        pend_mode_d = pend_mode_q;
        pend_d      = pend_q;
        tg_en_d     = 1'b0;
        ack_d       = 1'b0;
        err_mode_d  = 1'b0;
        err_to_d    = err_to_q;
        done_d      = 1'b0;
        frame_cnt_d = frame_cnt_q;
        to_cnt_d    = to_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (I_run && !err_to_q) state_d = pend_q ? S_LOAD : S_START;
            end
            S_LOAD: begin
                timing_d = preset(pend_mode_q);
                mode_d   = pend_mode_q;
                pend_d   = 1'b0;
                ack_d    = 1'b1;
                state_d  = S_START;
            end
            S_START: begin
                tg_en_d  = 1'b1;
                to_cnt_d = '0;
                state_d  = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (I_tg_busy) begin
                    state_d = S_RUN;
                end else if (to_cnt_q == TO_LAST) begin
                    err_to_d = 1'b1;
                    state_d  = S_IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            S_RUN: begin
                if (frame_end) begin
                    done_d      = 1'b1;
                    frame_cnt_d = frame_cnt_q + 1'b1;
                    if (!I_run)      state_d = S_IDLE;
                    else if (pend_q) state_d = S_LOAD;
                    else             state_d = S_START;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Capture after the case so a request landing in the S_LOAD cycle survives the clear.
        if (I_mode_req) begin
            if (I_mode == 2'd3) begin
                err_mode_d = 1'b1;
            end else begin
                pend_d      = 1'b1;
                pend_mode_d = I_mode;
            end
        end
    end

`ifdef HDMI_SEQ_MUTE_ON_SWITCH_EN
    localparam int MC_W = $clog2(MUTE_FRAMES + 1);
    logic            mute_q;
    logic [MC_W-1:0] mute_cnt_q;

    always_ff @(posedge I_pxl_clk or posedge I_rst) begin
        if (I_rst) begin
            mute_q     <= 1'b0;
            mute_cnt_q <= '0;
        end else if (state_q == S_LOAD) begin
            mute_q     <= 1'b1;
            mute_cnt_q <= MC_W'(MUTE_FRAMES);
        end else if (frame_end && mute_q) begin
            if (mute_cnt_q <= MC_W'(1)) mute_q <= 1'b0;
            mute_cnt_q <= mute_cnt_q - 1'b1;
        end
    end

    assign O_mute = mute_q || (state_q == S_LOAD);
`else
    assign O_mute = 1'b0;
`endif

    assign O_tg_en       = tg_en_q;
    assign O_h_total     = timing_q.h_total;
    assign O_h_sync      = timing_q.h_sync;
    assign O_h_bporch    = timing_q.h_bporch;
    assign O_h_res       = timing_q.h_res;
    assign O_v_total     = timing_q.v_total;
    assign O_v_sync      = timing_q.v_sync;
    assign O_v_bporch    = timing_q.v_bporch;
    assign O_v_res       = timing_q.v_res;
    assign O_mode        = mode_q;
    assign O_mode_ack    = ack_q;
    assign O_err_mode    = err_mode_q;
    assign O_err_timeout = err_to_q;
    assign O_frame_done  = done_q;
    assign O_frame_cnt   = frame_cnt_q;
    assign O_dbg_state   = state_q;

endmodule

// File: tb/tb_hdmi_mode_sequencer.sv
// Directed bench for hdmi_mode_sequencer with a simple timing-generator model and a mode-ack scoreboard.
module tb_hdmi_mode_sequencer;

  localparam int FW        = 16;
  localparam int FRAME_LEN = 12;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          run = 1'b0;
  logic          mode_req = 1'b0;
  logic [1:0]    mode_in = 2'd0;
  logic          busy = 1'b0;
  logic          tg_en, mode_ack, err_mode, err_timeout, frame_done, mute;
  logic [11:0]   h_total, h_sync, h_bporch, h_res, v_total, v_sync, v_bporch, v_res;
  logic [1:0]    mode_out;
  logic [FW-1:0] frame_cnt;
  logic [2:0]    dbg_state;

  int total = 0;
  int bad = 0;
  int model_cnt = 0;
  int ack_cnt = 0;
  int err_cnt = 0;
  bit gen_ok = 1'b1;
  logic [1:0] exp_q[$];

  logic [11:0] tab_h_total [3] = '{12'd1056, 12'd1344, 12'd1650};
  logic [11:0] tab_v_total [3] = '{12'd628, 12'd806, 12'd750};
  logic [11:0] tab_h_res   [3] = '{12'd800, 12'd1024, 12'd1280};
  logic [11:0] tab_v_res   [3] = '{12'd600, 12'd768, 12'd720};

  hdmi_mode_sequencer #(.DEFAULT_MODE(0), .FRAME_CNT_W(FW), .START_TIMEOUT(16), .MUTE_FRAMES(2)) dut (
    .I_pxl_clk(clk), .I_rst(rst), .I_run(run), .I_mode_req(mode_req), .I_mode(mode_in),
    .I_tg_busy(busy), .O_tg_en(tg_en),
    .O_h_total(h_total), .O_h_sync(h_sync), .O_h_bporch(h_bporch), .O_h_res(h_res),
    .O_v_total(v_total), .O_v_sync(v_sync), .O_v_bporch(v_bporch), .O_v_res(v_res),
    .O_mode(mode_out), .O_mode_ack(mode_ack), .O_err_mode(err_mode), .O_err_timeout(err_timeout),
    .O_frame_done(frame_done), .O_frame_cnt(frame_cnt), .O_mute(mute), .O_dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_busy();
    int n = 0;
    while (!busy && n < 100) begin tick(); n++; end
    if (!busy) check("wait_busy_timeout", 0, 1);
  endtask

  task automatic wait_frame();
    int n = 0;
    tick();
    while (!frame_done && n < 200) begin tick(); n++; end
    if (!frame_done) check("wait_frame_timeout", 0, 1);
  endtask

  task automatic request(input logic [1:0] m);
    mode_req = 1'b1;
    mode_in  = m;
    tick();
    mode_req = 1'b0;
  endtask

  // timing generator model; also checks the timing bus stays frozen for the whole frame
  logic [95:0] frozen;
  int left = 0;
  always @(negedge clk) begin
    if (rst) begin
      busy = 1'b0;
    end else if (!busy && tg_en && gen_ok) begin
      busy   = 1'b1;
      left   = FRAME_LEN;
      frozen = {h_total, h_sync, h_bporch, h_res, v_total, v_sync, v_bporch, v_res};
    end else if (busy) begin
      left--;
      if (left == 0) begin
        busy = 1'b0;
        check("timing_frozen", {h_total, h_sync, h_bporch, h_res, v_total, v_sync, v_bporch, v_res}, frozen);
      end
    end
  end

  // scoreboard / monitors
  always @(negedge clk) begin
    if (!rst) begin
      if (mode_ack) begin
        ack_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_ack", 1, 0);
        end else begin
          logic [1:0] m;
          m = exp_q.pop_front();
          check("ack_mode", mode_out, m);
          check("ack_h_total", h_total, tab_h_total[m]);
          check("ack_v_total", v_total, tab_v_total[m]);
          check("ack_h_res", h_res, tab_h_res[m]);
          check("ack_v_res", v_res, tab_v_res[m]);
        end
      end
      if (frame_done) begin
        model_cnt++;
        check("frame_cnt", frame_cnt, model_cnt);
      end
      if (err_mode) err_cnt++;
`ifndef HDMI_SEQ_MUTE_ON_SWITCH_EN
      if (mute) check("mute_idle", mute, 0);
`endif
    end
  end

  initial begin : stim
    int n;
    int pulses;
    int prev_ack;

    // reset state
    repeat (3) tick();
    check("rst_tg_en", tg_en, 0);
    check("rst_mode", mode_out, 0);
    check("rst_h_total", h_total, 1056);
    check("rst_h_res", h_res, 800);
    check("rst_v_res", v_res, 600);
    check("rst_v_sync", v_sync, 4);
    check("rst_frame_cnt", frame_cnt, 0);
    check("rst_err_timeout", err_timeout, 0);
    check("rst_mute", mute, 0);
    rst = 1'b0;
    tick();

    // run rise to enable latency: 2 cycles
    run = 1'b1;
    tick();
    check("lat_en_c1", tg_en, 0);
    tick();
    check("lat_en_c2", tg_en, 1);
    wait_frame();
    check("first_frame_cnt", frame_cnt, 1);
    check("first_h_res", h_res, 800);
    check("first_v_res", v_res, 600);

    // mid-frame switch to mode 2
    wait_busy();
    tick();
    exp_q.push_back(2'd2);
    prev_ack = ack_cnt;
    request(2'd2);
    tick();
    check("hold_h_total", h_total, 1056);
    check("hold_mode", mode_out, 0);
    wait_frame();
    check("hold_at_end", h_total, 1056);
    tick();
    check("ack_pulse", mode_ack, 1);
`ifdef HDMI_SEQ_MUTE_ON_SWITCH_EN
    check("mute_on", mute, 1);
`endif
    tick();
    check("ack_single", mode_ack, 0);
    check("m2_mode", mode_out, 2);
    check("m2_h_total", h_total, 1650);
    check("m2_v_total", v_total, 750);
`ifdef HDMI_SEQ_MUTE_ON_SWITCH_EN
    wait_frame();
    tick();
    check("mute_frame1", mute, 1);
    wait_frame();
    tick();
    check("mute_frame2", mute, 0);
`endif

    // two requests in one frame: last wins, one ack
    wait_busy();
    tick();
    exp_q.push_back(2'd0);
    prev_ack = ack_cnt;
    request(2'd1);
    request(2'd0);
    wait_frame();
    repeat (3) tick();
    check("last_wins_ack_cnt", ack_cnt, prev_ack + 1);
    check("last_wins_mode", mode_out, 0);
    check("last_wins_h_res", h_res, 800);

    // illegal mode request
    wait_busy();
    tick();
    prev_ack = ack_cnt;
    request(2'd3);
    check("err_mode_pulse", err_mode, 1);
    tick();
    check("err_mode_single", err_mode, 0);
    wait_frame();
    repeat (3) tick();
    check("illegal_mode_kept", mode_out, 0);
    check("illegal_no_ack", ack_cnt, prev_ack);
    check("err_mode_cnt", err_cnt, 1);

    // run drop mid-frame: frame completes, no new frame starts
    wait_busy();
    tick();
    run = 1'b0;
    n = model_cnt;
    wait_frame();
    check("stop_frame_done", frame_cnt, n + 1);
    pulses = 0;
    repeat (30) begin tick(); if (tg_en) pulses++; end
    check("stop_no_enable", pulses, 0);

    // start timeout: generator never answers
    gen_ok = 1'b0;
    run = 1'b1;
    n = 0;
    while (!tg_en && n < 10) begin tick(); n++; end
    check("to_enable_seen", tg_en, 1);
    n = 0;
    while (!err_timeout && n < 40) begin tick(); n++; end
    check("to_cycles", n, 16);
    pulses = 0;
    repeat (40) begin tick(); if (tg_en) pulses++; end
    check("to_sticky", err_timeout, 1);
    check("to_no_enable", pulses, 0);

    // reset clears everything
    run = 1'b0;
    rst = 1'b1;
    tick();
    model_cnt = 0;
    check("rst2_err_timeout", err_timeout, 0);
    check("rst2_frame_cnt", frame_cnt, 0);
    check("rst2_mode", mode_out, 0);
    check("rst2_h_total", h_total, 1056);
    rst = 1'b0;
    tick();
    check("queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/hdmi_mode_sequencer.md
Name: hdmi_mode_sequencer

Overview:
Frame-level controller for the HDMI timing generator. Holds three video-mode presets, drives the generator's enable and 12-bit timing bus, and starts one frame at a time. Mode changes are accepted at any time and take effect only at a frame boundary, so no frame is ever emitted with mixed timing. Sits between the system control logic and the timing generator in the HDMI TX path.

Parameters:
DEFAULT_MODE, 0, preset loaded at reset (0=800x600, 1=1024x768, 2=1280x720)
FRAME_CNT_W, 16, width of the frame counter
START_TIMEOUT, 16, cycles to wait for generator busy after an enable pulse
MUTE_FRAMES, 2, frames muted after a mode switch (optional feature only)

Ports:
I_pxl_clk  in  1  pixel clock
I_rst  in  1  asynchronous reset, active high
I_run  in  1  level; 1 = keep generating frames
I_mode_req  in  1  one-cycle mode-change request strobe
I_mode  in  2  requested mode, sampled when I_mode_req=1
I_tg_busy  in  1  busy flag from the timing generator
O_tg_en  out  1  enable pulse to the timing generator
O_h_total, O_h_sync, O_h_bporch, O_h_res  out  12 each  horizontal timing to generator
O_v_total, O_v_sync, O_v_bporch, O_v_res  out  12 each  vertical timing to generator
O_mode  out  2  currently applied mode
O_mode_ack  out  1  one-cycle pulse when a pending mode is applied
O_err_mode  out  1  one-cycle pulse when an illegal mode (3) is requested
O_err_timeout  out  1  sticky; generator never went busy
O_frame_done  out  1  one-cycle pulse per completed frame
O_frame_cnt  out  FRAME_CNT_W  completed-frame count
O_mute  out  1  video mute to pattern/data source

Behaviour:
- Reset (async, I_rst=1): state S_IDLE; O_tg_en=0, O_mode_ack=0, O_err_mode=0, O_err_timeout=0, O_frame_done=0, O_frame_cnt=0, O_mute=0; O_mode=DEFAULT_MODE; timing outputs = DEFAULT_MODE preset; pending flag cleared.
- Presets (total/sync/bporch/res): mode0 H 1056/128/88/800, V 628/4/23/600; mode1 H 1344/136/160/1024, V 806/6/29/768; mode2 H 1650/40/220/1280, V 750/5/20/720.
- Request capture: I_mode_req=1 with I_mode<=2 -> pending_mode=I_mode, pending=1; last request wins. I_mode=3 -> O_err_mode pulse next cycle, pending untouched.
- S_IDLE: O_tg_en=0. If I_run=1 and O_err_timeout=0 -> S_LOAD if pending, else S_START.
- S_LOAD (1 cycle): timing outputs and O_mode <= preset[pending_mode]; pending=0; O_mode_ack pulses next cycle -> S_START. A request arriving in the S_LOAD cycle is stored as new pending (not lost).
- S_START (1 cycle): O_tg_en=1 registered, timeout counter cleared -> S_WAIT_BUSY.
- S_WAIT_BUSY: I_tg_busy=1 -> S_RUN. After START_TIMEOUT cycles without busy -> O_err_timeout=1 (sticky until reset), S_IDLE.
- S_RUN: timing outputs frozen. On I_tg_busy 1->0: O_frame_done pulse, O_frame_cnt+1 (wraps to 0 at all-ones); then I_run=0 -> S_IDLE, else pending -> S_LOAD, else S_START.
- I_run deassert mid-frame: current frame always completes; no truncation.
- Timing outputs change only in S_LOAD; never while I_tg_busy=1.
- Latency: I_run rise to O_tg_en = 2 cycles (no pending) or 3 cycles (pending).
- Reset mid-frame: immediate return to reset values; generator is expected to be reset by the same I_rst domain.

Optional Feature:
Macro HDMI_SEQ_MUTE_ON_SWITCH_EN. Defined: O_mute=1 from the S_LOAD cycle until MUTE_FRAMES further frames complete, then 0; a new switch during mute restarts the count. Undefined: O_mute constant 0, no mute counter logic.

Test Plan:
- Reset, I_run=1, model generator busy 1 frame then idle -> O_tg_en at cycle 2, O_h_res=800, O_v_res=600, O_frame_cnt=1 after first busy fall.
- I_mode_req with I_mode=2 mid-frame -> outputs unchanged until busy falls; then O_h_total=1650, O_v_total=750, O_mode=2, one O_mode_ack pulse.
- Requests mode1 then mode2 in same frame -> only mode2 applied, single ack.
- I_mode=3 request -> one O_err_mode pulse, O_mode unchanged, no ack.
- Generator held non-busy after enable -> O_err_timeout=1 after 16 cycles, O_tg_en stays 0 afterward until reset.
- With HDMI_SEQ_MUTE_ON_SWITCH_EN, switch to mode1 -> O_mute high for exactly 2 completed frames; without macro O_mute=0 throughout.
